regfile_wb_sched: RTL and testbench

//   Writeback scheduler and hazard scoreboard for the 32-entry integer register file.

---
 rtl/regfile_wb_sched.sv | 130 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the integer register file: round-robin sharing of the single
// write port between result producers, plus a busy scoreboard that stalls issue on RAW/WAW.
module regfile_wb_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [5*NREQ-1:0]          req_rd,
    input  logic [DATA_WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    input  logic [4:0]                 issue_rs1,
    input  logic [4:0]                 issue_rs2,
    output logic                       issue_stall,
    output logic                       wb_we,
    output logic [4:0]                 wb_rd,
    output logic [DATA_WIDTH-1:0]      wb_data
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [31:0]           busy_q,    busy_d;
    logic                  wb_we_q,   wb_we_d;
    logic [4:0]            wb_rd_q,   wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;
    logic [NREQ-1:0]       grant_oh;
    logic                  accept;
    logic [4:0]            acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  issue_fire;

    // Scan from rr_ptr with wrap; only req_valid feeds the decision, never rd/data.
    always_comb begin : arbiter
        int idx;
        // NOTE: every variable driven here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin : grant_decode
        grant_oh = '0;
        if (grant_found && !rst) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_oh;
    assign accept    = grant_found & ~rst;

    always_comb begin : accept_mux
        acc_rd   = req_rd[int'(grant_idx)*5 +: 5];
        acc_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin : rr_next
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // x0 accepts still complete the handshake and update rd/data, but never raise the write enable.
    always_comb begin : wb_next
        wb_we_d   = accept & (acc_rd != 5'd0);
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (accept) begin
            wb_rd_d   = acc_rd;
            wb_data_d = acc_data;
        end
    end

    assign issue_stall = issue_valid & ~rst &
                         (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
    assign issue_fire  = issue_valid & ~issue_stall & (issue_rd != 5'd0);

    // Set is applied after clear so a newer producer of the same rd keeps it busy.
    always_comb begin : busy_next
        busy_d = busy_q;
        if (accept) begin
            busy_d[acc_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, round-robin order, RAW/WAW stalls, x0, set/clear collision, mid-op reset.
module tb_regfile_wb_sched;

    localparam int DW = 32;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [5*NR-1:0] req_rd;
    logic [DW*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            issue_valid;
    logic [4:0]      issue_rd, issue_rs1, issue_rs2;
    logic            issue_stall;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [DW-1:0]   wb_data;

    int n_checks = 0;
    int n_bad    = 0;

    regfile_wb_sched #(.DATA_WIDTH(DW), .NREQ(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = v;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        req_rd    = {5'd7, 5'd6, 5'd5};
        req_data  = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
        issue(1'b1, 5'd9, 5'd9, 5'd9);

        // 1. Reset with every requester valid
        step();
        step();
        #1;
        check("rst_ready",  32'(req_ready), 32'h0);
        check("rst_we",     32'(wb_we), 32'h0);
        check("rst_rd",     32'(wb_rd), 32'h0);
        check("rst_data",   wb_data, 32'h0);
        check("rst_stall",  32'(issue_stall), 32'h0);

        // 2. Round robin, all three held valid
        rst = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("rr_first_grant", 32'(req_ready), 32'b001);
        step();
        check("rr_g1",   32'(req_ready), 32'b010);
        check("rr_we1",  32'(wb_we), 32'h1);
        check("rr_rd1",  32'(wb_rd), 32'd5);
        check("rr_d1",   wb_data, 32'hC0C0_0000);
        step();
        check("rr_g2",   32'(req_ready), 32'b100);
        check("rr_we2",  32'(wb_we), 32'h1);
        check("rr_rd2",  32'(wb_rd), 32'd6);
        check("rr_d2",   wb_data, 32'hC1C1_0001);
        step();
        check("rr_g3",   32'(req_ready), 32'b001);
        check("rr_we3",  32'(wb_we), 32'h1);
        check("rr_rd3",  32'(wb_rd), 32'd7);
        step();
        check("rr_we4",  32'(wb_we), 32'h1);
        check("rr_rd4",  32'(wb_rd), 32'd5);
        req_valid = '0;
        #1;
        check("rr_idle_ready", 32'(req_ready), 32'h0);
        step();
        check("rr_idle_we", 32'(wb_we), 32'h0);
        // rr_ptr now 1

        // 3. RAW on rs1
        issue(1'b1, 5'd10, 5'd0, 5'd0);
        #1;
        check("raw_issue_nostall", 32'(issue_stall), 32'h0);
        step();
        issue(1'b1, 5'd0, 5'd10, 5'd0);
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd10};
        req_data  = {32'h0, 32'h0, 32'hDEAD_BEEF};
        #1;
        check("raw_stall",       32'(issue_stall), 32'h1);
        check("raw_ready_wrap",  32'(req_ready), 32'b001);
        step();
        check("raw_unstall", 32'(issue_stall), 32'h0);
        check("raw_we",      32'(wb_we), 32'h1);
        check("raw_rd",      32'(wb_rd), 32'd10);
        check("raw_data",    wb_data, 32'hDEAD_BEEF);
        req_valid = '0;
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        // rr_ptr now 1

        // 4. x0 writeback and x0 issue
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd0, 5'd0};
        req_data  = {32'h0, 32'h0000_1234, 32'h0};
        issue(1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_ready", 32'(req_ready), 32'b010);
        check("x0_issue_nostall", 32'(issue_stall), 32'h0);
        step();
        check("x0_we",   32'(wb_we), 32'h0);
        check("x0_rd",   32'(wb_rd), 32'd0);
        check("x0_data", wb_data, 32'h0000_1234);
        check("x0_no_busy", 32'(issue_stall), 32'h0);
        req_valid = '0;
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        // rr_ptr now 2

        // 5. Same-cycle set and clear of rd=12: set must win
        req_valid = 3'b100;
        req_rd    = {5'd12, 5'd0, 5'd0};
        req_data  = {32'h0000_0C0C, 32'h0, 32'h0};
        issue(1'b1, 5'd12, 5'd0, 5'd0);
        #1;
        check("col_ready", 32'(req_ready), 32'b100);
        check("col_issue_nostall", 32'(issue_stall), 32'h0);
        step();
        req_valid = '0;
        check("col_we", 32'(wb_we), 32'h1);
        check("col_rd", 32'(wb_rd), 32'd12);
        issue(1'b1, 5'd12, 5'd0, 5'd0);
        #1;
        check("col_waw_stall", 32'(issue_stall), 32'h1);
        issue(1'b1, 5'd13, 5'd12, 5'd0);
        #1;
        check("col_raw_stall", 32'(issue_stall), 32'h1);
        // retire rd=12 through req 0 (rr_ptr now 0)
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd12};
        #1;
        check("col_clear_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        issue(1'b1, 5'd0, 5'd0, 5'd12);
        #1;
        check("col_cleared", 32'(issue_stall), 32'h0);
        // rr_ptr now 1

        // 6. Reset mid-operation
        issue(1'b1, 5'd3, 5'd0, 5'd0);
        step();
        issue(1'b1, 5'd4, 5'd0, 5'd0);
        step();
        issue(1'b1, 5'd0, 5'd4, 5'd3);
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd3, 5'd0};
        req_data  = {32'h0, 32'h0000_0033, 32'h0};
        #1;
        check("mid_busy_stall", 32'(issue_stall), 32'h1);
        check("mid_ready", 32'(req_ready), 32'b010);
        step();
        rst       = 1'b1;
        req_valid = 3'b111;
        req_rd    = {5'd7, 5'd6, 5'd5};
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_stall", 32'(issue_stall), 32'h0);
        check("mid_wb_rd_before", 32'(wb_rd), 32'd3);
        step();
        check("mid_we", 32'(wb_we), 32'h0);
        check("mid_rd", 32'(wb_rd), 32'd0);
        check("mid_data", wb_data, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_busy_cleared", 32'(issue_stall), 32'h0);
        check("mid_rr_ptr_zero", 32'(req_ready), 32'b001);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
